// File: rtl/fpu_ss_regfile_sb.sv
// FPU subsystem floating-point register file with an integrated busy scoreboard.
// Combinational read ports, two write ports (A = FPU result, B = load data),
// and one reservation port used by the issue stage.
// Optional macro FPU_SS_REGFILE_BYPASS_EN: same-cycle write-to-read forwarding.
module fpu_ss_regfile_sb #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NumRead   = 3,
    parameter int unsigned AddrWidth = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [AddrWidth-1:0]         raddr_i [NumRead],
    output logic [DataWidth-1:0]         rdata_o [NumRead],
    output logic [NumRead-1:0]           rbusy_o,
    input  logic                         rsv_valid_i,
    input  logic [AddrWidth-1:0]         rsv_addr_i,
    output logic                         rsv_ready_o,
    input  logic                         wa_valid_i,
    input  logic [AddrWidth-1:0]         wa_addr_i,
    input  logic [DataWidth-1:0]         wa_data_i,
    input  logic                         wb_valid_i,
    input  logic [AddrWidth-1:0]         wb_addr_i,
    input  logic [DataWidth-1:0]         wb_data_i,
    output logic [(2**AddrWidth)-1:0]    busy_o,
    output logic                         collision_o
);

    localparam int unsigned NumWords = 2 ** AddrWidth;

    logic [DataWidth-1:0] mem_q [NumWords];
    logic [NumWords-1:0]  busy_q;
    logic [NumWords-1:0]  busy_d;
    logic [NumWords-1:0]  wr_hit;
    logic [NumWords-1:0]  rsv_set;
    logic                 collision_q;
    logic                 collide;

    assign collide     = wa_valid_i & wb_valid_i & (wa_addr_i == wb_addr_i);
    assign busy_o      = busy_q;
    assign collision_o = collision_q;

    // Per-register write hits; a write releases its register.
    always_comb begin
        wr_hit = '0;
        for (int unsigned w = 0; w < NumWords; w++) begin
            wr_hit[w] = (wa_valid_i && (wa_addr_i == AddrWidth'(w))) ||
                        (wb_valid_i && (wb_addr_i == AddrWidth'(w)));
        end
    end

    // Reservation acceptance: free register, or one released by a write this cycle.
    always_comb begin
        rsv_ready_o = rsv_valid_i & (~busy_q[rsv_addr_i] | wr_hit[rsv_addr_i]);
        rsv_set     = '0;
        if (rsv_ready_o) begin
            rsv_set[rsv_addr_i] = 1'b1;
        end
        busy_d = rsv_set | (busy_q & ~wr_hit);
    end

    // Storage and scoreboard state; port A takes priority on a shared address.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned w = 0; w < NumWords; w++) begin
                mem_q[w] <= '0;
            end
            busy_q      <= '0;
            collision_q <= 1'b0;
        end else begin
            for (int unsigned w = 0; w < NumWords; w++) begin
                if (wa_valid_i && (wa_addr_i == AddrWidth'(w))) begin
                    mem_q[w] <= wa_data_i;
                end else if (wb_valid_i && (wb_addr_i == AddrWidth'(w))) begin
                    mem_q[w] <= wb_data_i;
                end
            end
            busy_q      <= busy_d;
            collision_q <= collide;
        end
    end

    // Read ports: registered state, optionally overlaid with same-cycle writes.
    always_comb begin
        for (int unsigned i = 0; i < NumRead; i++) begin
            rdata_o[i] = mem_q[raddr_i[i]];
            rbusy_o[i] = busy_q[raddr_i[i]];
`ifdef FPU_SS_REGFILE_BYPASS_EN
            // B first so that A overrides it when both target the same address.
            if (wb_valid_i && (wb_addr_i == raddr_i[i])) begin
                rdata_o[i] = wb_data_i;
                rbusy_o[i] = rsv_set[raddr_i[i]];
            end
            if (wa_valid_i && (wa_addr_i == raddr_i[i])) begin
                rdata_o[i] = wa_data_i;
                rbusy_o[i] = rsv_set[raddr_i[i]];
            end
`endif
        end
    end

endmodule

// File: tb/tb_fpu_ss_regfile_sb.sv
// Directed self-checking bench for fpu_ss_regfile_sb (default parameters).
module tb_fpu_ss_regfile_sb;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 3;
    localparam int unsigned AW = 5;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [AW-1:0] raddr_i [NR];
    logic [DW-1:0] rdata_o [NR];
    logic [NR-1:0] rbusy_o;
    logic          rsv_valid_i = 1'b0;
    logic [AW-1:0] rsv_addr_i  = '0;
    logic          rsv_ready_o;
    logic          wa_valid_i  = 1'b0;
    logic [AW-1:0] wa_addr_i   = '0;
    logic [DW-1:0] wa_data_i   = '0;
    logic          wb_valid_i  = 1'b0;
    logic [AW-1:0] wb_addr_i   = '0;
    logic [DW-1:0] wb_data_i   = '0;
    logic [31:0]   busy_o;
    logic          collision_o;

    int n_tests = 0;
    int n_fail  = 0;

    fpu_ss_regfile_sb #(
        .DataWidth (DW),
        .NumRead   (NR),
        .AddrWidth (AW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .raddr_i     (raddr_i),
        .rdata_o     (rdata_o),
        .rbusy_o     (rbusy_o),
        .rsv_valid_i (rsv_valid_i),
        .rsv_addr_i  (rsv_addr_i),
        .rsv_ready_o (rsv_ready_o),
        .wa_valid_i  (wa_valid_i),
        .wa_addr_i   (wa_addr_i),
        .wa_data_i   (wa_data_i),
        .wb_valid_i  (wb_valid_i),
        .wb_addr_i   (wb_addr_i),
        .wb_data_i   (wb_data_i),
        .busy_o      (busy_o),
        .collision_o (collision_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then drop all request strobes and let outputs settle.
    task automatic tick();
        @(posedge clk_i);
        #1;
        rsv_valid_i = 1'b0;
        wa_valid_i  = 1'b0;
        wb_valid_i  = 1'b0;
        #1;
    endtask

    initial begin
        raddr_i[0] = 5'd0;
        raddr_i[1] = 5'd5;
        raddr_i[2] = 5'd31;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("rst_rdata0", 64'(rdata_o[0]), 64'h0);
        check_eq("rst_rdata1", 64'(rdata_o[1]), 64'h0);
        check_eq("rst_rdata2", 64'(rdata_o[2]), 64'h0);
        check_eq("rst_busy", 64'(busy_o), 64'h0);
        check_eq("rst_coll", 64'(collision_o), 64'h0);
        rsv_valid_i = 1'b1;
        rsv_addr_i  = 5'd0;
        #1;
        check_eq("rst_ready", 64'(rsv_ready_o), 64'h1);
        rsv_valid_i = 1'b0;
        rst_i       = 1'b0;

        // First write after reset
        wa_valid_i = 1'b1; wa_addr_i = 5'd5; wa_data_i = 32'h3F80_0000;
        #1;
`ifdef FPU_SS_REGFILE_BYPASS_EN
        check_eq("wr5_same", 64'(rdata_o[1]), 64'h3F80_0000);
`else
        check_eq("wr5_same", 64'(rdata_o[1]), 64'h0);
`endif
        tick();
        check_eq("wr5_next", 64'(rdata_o[1]), 64'h3F80_0000);

        // Scoreboard cycle on register 7
        raddr_i[0]  = 5'd7;
        rsv_valid_i = 1'b1; rsv_addr_i = 5'd7;
        #1;
        check_eq("rsv7_ready", 64'(rsv_ready_o), 64'h1);
        tick();
        check_eq("rsv7_busy", 64'(busy_o[7]), 64'h1);
        check_eq("rsv7_rbusy", 64'(rbusy_o[0]), 64'h1);
        rsv_valid_i = 1'b1;
        #1;
        check_eq("rsv7_again", 64'(rsv_ready_o), 64'h0);
        rsv_valid_i = 1'b0;
        wb_valid_i = 1'b1; wb_addr_i = 5'd7; wb_data_i = 32'h4049_0FDB;
        tick();
        check_eq("rel7_busy", 64'(busy_o[7]), 64'h0);
        check_eq("rel7_data", 64'(rdata_o[0]), 64'h4049_0FDB);
        check_eq("rel7_rbusy", 64'(rbusy_o[0]), 64'h0);

        // Same-cycle release and reserve on register 3
        raddr_i[2]  = 5'd3;
        rsv_valid_i = 1'b1; rsv_addr_i = 5'd3;
        tick();
        check_eq("rsv3_busy", 64'(busy_o[3]), 64'h1);
        wa_valid_i = 1'b1; wa_addr_i = 5'd3; wa_data_i = 32'hDEAD_BEEF;
        rsv_valid_i = 1'b1; rsv_addr_i = 5'd3;
        #1;
        check_eq("relrsv3_ready", 64'(rsv_ready_o), 64'h1);
        tick();
        check_eq("relrsv3_busy", 64'(busy_o[3]), 64'h1);
        check_eq("relrsv3_data", 64'(rdata_o[2]), 64'hDEAD_BEEF);

        // Write collision on register 9
        raddr_i[0] = 5'd9;
        raddr_i[1] = 5'd10;
        wa_valid_i = 1'b1; wa_addr_i = 5'd9; wa_data_i = 32'h1111_1111;
        wb_valid_i = 1'b1; wb_addr_i = 5'd9; wb_data_i = 32'h2222_2222;
        tick();
        check_eq("coll_pulse", 64'(collision_o), 64'h1);
        check_eq("coll_data", 64'(rdata_o[0]), 64'h1111_1111);
        check_eq("unrsv_busy9", 64'(busy_o[9]), 64'h0);
        wa_valid_i = 1'b1; wa_addr_i = 5'd9;  wa_data_i = 32'h3333_3333;
        wb_valid_i = 1'b1; wb_addr_i = 5'd10; wb_data_i = 32'h4444_4444;
        tick();
        check_eq("nocoll", 64'(collision_o), 64'h0);
        check_eq("dual9", 64'(rdata_o[0]), 64'h3333_3333);
        check_eq("dual10", 64'(rdata_o[1]), 64'h4444_4444);

        // Back-to-back collisions keep the flag high
        for (int k = 0; k < 2; k++) begin
            wa_valid_i = 1'b1; wa_addr_i = 5'd12; wa_data_i = 32'hA5A5_0000 + k;
            wb_valid_i = 1'b1; wb_addr_i = 5'd12; wb_data_i = 32'h5A5A_0000;
            tick();
            check_eq("b2b_coll", 64'(collision_o), 64'h1);
        end
        tick();
        check_eq("b2b_end", 64'(collision_o), 64'h0);
        check_eq("busy_vec", 64'(busy_o), 64'h0000_0008);

        // Same-cycle visibility of a write to register 2
        raddr_i[2] = 5'd2;
        wa_valid_i = 1'b1; wa_addr_i = 5'd2; wa_data_i = 32'h5444_2D18;
        #1;
`ifdef FPU_SS_REGFILE_BYPASS_EN
        check_eq("byp_data", 64'(rdata_o[2]), 64'h5444_2D18);
`else
        check_eq("byp_data", 64'(rdata_o[2]), 64'h0);
`endif
        check_eq("byp_rbusy", 64'(rbusy_o[2]), 64'h0);
        tick();
        check_eq("wr2_next", 64'(rdata_o[2]), 64'h5444_2D18);

        // Asynchronous reset mid-cycle
        rsv_valid_i = 1'b1; rsv_addr_i = 5'd4;
        tick();
        check_eq("rsv4_busy", 64'(busy_o[4]), 64'h1);
        #2;
        rst_i = 1'b1;
        #1;
        check_eq("arst_busy", 64'(busy_o), 64'h0);
        check_eq("arst_rdata0", 64'(rdata_o[0]), 64'h0);
        check_eq("arst_rdata2", 64'(rdata_o[2]), 64'h0);
        tick();
        rst_i = 1'b0;
        wb_valid_i = 1'b1; wb_addr_i = 5'd9; wb_data_i = 32'hCAFE_F00D;
        tick();
        check_eq("post_rst_wr", 64'(rdata_o[0]), 64'hCAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fpu_ss_regfile_sb.md
# fpu_ss_regfile_sb

Parametrised floating-point register file for the FPU subsystem with a configurable number of combinational read ports, two write ports (FPU result writeback and memory-load writeback), and an integrated per-register busy scoreboard. The issue stage reserves a destination register, either write port releases it, and the decoder stalls on the busy flags returned with each read. It sits between the FPU subsystem decoder/issue logic and the FPU/LSU writeback paths, and it supports FLEN=64 and extra read ports for coprocessor arbiters.

## Interface
- DataWidth, 32: register width in bits (32 or 64).
- NumRead, 3: number of read ports (1..8).
- AddrWidth, 5: register address width; NumWords = 2**AddrWidth.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- raddr_i  in  NumRead x AddrWidth  read addresses.
- rdata_o  out  NumRead x DataWidth  read data.
- rbusy_o  out  NumRead  busy flag of each addressed register.
- rsv_valid_i  in  1  reserve request for rsv_addr_i.
- rsv_addr_i  in  AddrWidth  register to reserve.
- rsv_ready_o  out  1  reservation accepted this cycle.
- wa_valid_i, wa_addr_i, wa_data_i  in  1/AddrWidth/DataWidth  write port A (FPU result).
- wb_valid_i, wb_addr_i, wb_data_i  in  1/AddrWidth/DataWidth  write port B (load data).
- busy_o  out  NumWords  full scoreboard vector.
- collision_o  out  1  registered one-cycle pulse: A and B wrote the same address.

## Operation
- Storage: NumWords x DataWidth flops. Register 0 is an ordinary register and is not hardwired to zero.
- Reads are combinational: rdata_o[i] = mem[raddr_i[i]] and rbusy_o[i] = busy[raddr_i[i]].
- Writes: a port with valid=1 updates mem[addr] at the clock edge and clears busy[addr].
- Both ports write the same address in one cycle:
  - Port A wins. Port B's data is dropped.
  - collision_o = 1 for the following cycle.
- Both ports write different addresses in one cycle: both commit.
- A write to a non-busy register is legal (for example, an unreserved load). It commits and busy stays 0.
- rsv_ready_o = rsv_valid_i & (~busy[rsv_addr_i] | write to rsv_addr_i this cycle), where "write" means wa_valid_i or wb_valid_i hitting that address.
- Accepted reservation: busy[rsv_addr_i] = 1 at the next edge. A set wins over a same-cycle clear on the same address.
- Rejected reservation (register busy, no releasing write): no state change. The requester holds valid until ready; rsv_ready_o is a pure combinational function of its inputs and the current state.
- Per-register busy next state = set | (busy & ~clear). No counter; a register is either reserved or not.

## Timing
- Reset (rst_i = 1, asynchronous) clears, effective immediately:
  - all mem words to 0;
  - busy_o to all 0;
  - collision_o to 0.
  Hence rdata_o = 0, rbusy_o = 0 and rsv_ready_o = rsv_valid_i.
- Reset asserted mid-operation discards all reservations and pending same-edge writes. The first edge after rst_i deasserts is a normal cycle.
- Write-to-read latency is 1 cycle without bypass: data written at edge N is visible on rdata_o after edge N.
- Busy clear latency is 1 cycle; reservation set latency is 1 cycle.
- collision_o is high for exactly the cycle after a colliding edge. Back-to-back collisions keep it high.

## Configuration
- Macro FPU_SS_REGFILE_BYPASS_EN.
- Defined: same-cycle forwarding on every read port.
  - If raddr_i[i] matches an active write address, rdata_o[i] returns that write's data (port A over port B) and rbusy_o[i] = 0, unless a same-cycle accepted reservation targets that address, in which case rbusy_o[i] = 1.
  - Zero-cycle write-to-read latency.
- Undefined: no forwarding. Reads see only registered state, and rbusy_o reflects registered busy only.

## Test plan
- Reset behaviour: hold rst_i, drive raddr_i = {0,5,31} -> rdata_o all 0, busy_o = 0, collision_o = 0. Release reset, write A addr 5 = 0x3F800000 -> next cycle rdata_o[1] = 0x3F800000.
- Scoreboard cycle:
  - reserve addr 7 -> busy_o[7] = 1 next cycle;
  - reserve 7 again -> rsv_ready_o = 0;
  - write B addr 7 = 0x40490FDB -> busy_o[7] = 0 next cycle and data readable.
- Same-cycle release and reserve: busy[3] = 1; write A addr 3 and reserve 3 in one cycle -> rsv_ready_o = 1, and busy_o[3] = 1 after the edge with new data stored.
- Write collision: A and B both write addr 9 with 0x11111111 / 0x22222222 -> mem[9] = 0x11111111 and collision_o = 1 for exactly one cycle. Different addresses 9/10 -> both stored, no collision.
- Async reset mid-operation: reserve 4, then assert rst_i between edges -> busy_o = 0 and rdata_o = 0 immediately without a clock edge.
- With FPU_SS_REGFILE_BYPASS_EN, at DataWidth = 64 and NumRead = 4: write A addr 2 = 0x400921FB54442D18 while raddr_i[3] = 2 -> same-cycle rdata_o[3] = 0x400921FB54442D18 and rbusy_o[3] = 0. Without the macro, the old value is returned that cycle.
